// File: rtl/class_hvec_scan_ctrl.sv
// -----------------------------------------------------------------------------
// class_hvec_scan_ctrl
//
// Sequencer for the class hypervector ROM. A start pulse latches a class mask.
// The block then addresses every enabled class in ascending order, and every
// frame within each class. Each ROM slice is registered into a single output
// stage. That stage is offered downstream over a valid/ready handshake, one
// beat per cycle when there is no backpressure.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start_i         one-cycle pulse that starts a scan (only honoured in IDLE)
//   abort_i         cancels a scan in progress (takes priority over everything)
//   class_mask_i    per-class enable, latched when a start is accepted
//   frame_id_o      ROM address, class part
//   frame_index_o   ROM address, frame part
//   class_vec_i     ROM data, combinational from the address outputs
//   out_valid_o     beat valid
//   out_ready_i     downstream accepts the beat
//   out_data_o      registered class-vector slice
//   out_class_o     class tag of the beat
//   out_frame_o     frame tag of the beat
//   out_last_o      final beat of the scan
//   busy_o          controller is not IDLE
//   done_o          one-cycle pulse after the last beat has been accepted
// -----------------------------------------------------------------------------
module class_hvec_scan_ctrl #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = 8,
  parameter int N_FRAMES           = 3,
  parameter int CLASS_W            = 3,
  parameter int FRAME_W            = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [N_CLASSES-1:0]          class_mask_i,
  output logic [CLASS_W-1:0]            frame_id_o,
  output logic [FRAME_W-1:0]            frame_index_o,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DI_PARALLEL_W_BITS-1:0] out_data_o,
  output logic [CLASS_W-1:0]            out_class_o,
  output logic [FRAME_W-1:0]            out_frame_o,
  output logic                          out_last_o,
  output logic                          busy_o,
  output logic                          done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(N_FRAMES - 1);

  state_t                          state_q, state_d;
  logic [N_CLASSES-1:0]            mask_q, mask_d;
  logic [CLASS_W-1:0]              frame_id_q, frame_id_d;
  logic [FRAME_W-1:0]              frame_index_q, frame_index_d;

  logic [DI_PARALLEL_W_BITS-1:0]   data_p0, data_nxt;
  logic [CLASS_W-1:0]              class_p0, class_nxt;
  logic [FRAME_W-1:0]              frame_p0, frame_nxt;
  logic                            vld_p0, vld_nxt;
  logic                            last_p0, last_nxt;

  logic                            load;
  logic                            at_last_addr;
  logic [CLASS_W-1:0]              top_class;

  // Lowest enabled class in a mask (0 when the mask is empty).
  function automatic logic [CLASS_W-1:0] lowest_class(input logic [N_CLASSES-1:0] m);
    logic [CLASS_W-1:0] r;
    r = '0;
    for (int c = N_CLASSES - 1; c >= 0; c--) begin
      if (m[c]) r = CLASS_W'(c);
    end
    return r;
  endfunction

  // Highest enabled class in a mask (0 when the mask is empty).
  function automatic logic [CLASS_W-1:0] highest_class(input logic [N_CLASSES-1:0] m);
    logic [CLASS_W-1:0] r;
    r = '0;
    for (int c = 0; c < N_CLASSES; c++) begin
      if (m[c]) r = CLASS_W'(c);
    end
    return r;
  endfunction

  // First enabled class strictly above cur. If there is none, cur is returned.
  // The caller never asks beyond the top class, because the top class ends the scan.
  function automatic logic [CLASS_W-1:0] next_class(input logic [N_CLASSES-1:0] m,
                                                    input logic [CLASS_W-1:0]   cur);
    logic [CLASS_W-1:0] r;
    logic               found;
    r     = cur;
    found = 1'b0;
    for (int c = 0; c < N_CLASSES; c++) begin
      if (!found && (c > int'(cur)) && m[c]) begin
        r     = CLASS_W'(c);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign top_class    = highest_class(mask_q);
  assign at_last_addr = (frame_id_q == top_class) && (frame_index_q == LAST_FRAME);
  // The output stage can take a new slice when it is empty or is being emptied this cycle.
  assign load         = !vld_p0 || out_ready_i;

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    frame_id_d    = frame_id_q;
    frame_index_d = frame_index_q;
    data_nxt      = data_p0;
    class_nxt     = class_p0;
    frame_nxt     = frame_p0;
    vld_nxt       = vld_p0;
    last_nxt      = last_p0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (|class_mask_i) begin
            mask_d        = class_mask_i;
            frame_id_d    = lowest_class(class_mask_i);
            frame_index_d = '0;
            state_d       = RUN;
          end else begin
            state_d = FIN;
          end
        end
      end

      RUN: begin
        if (load) begin
          data_nxt  = class_vec_i;
          class_nxt = frame_id_q;
          frame_nxt = frame_index_q;
          vld_nxt   = 1'b1;
          last_nxt  = at_last_addr;
          if (at_last_addr) begin
            // The address holds here. Only the final beat remains, to be drained.
            state_d = DRAIN;
          end else if (frame_index_q == LAST_FRAME) begin
            frame_index_d = '0;
            frame_id_d    = next_class(mask_q, frame_id_q);
          end else begin
            frame_index_d = frame_index_q + FRAME_W'(1);
          end
        end
      end

      DRAIN: begin
        if (vld_p0 && out_ready_i) begin
          vld_nxt  = 1'b0;
          last_nxt = 1'b0;
          state_d  = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides both the start pulse and the handshake, and gives no done pulse.
    if (abort_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      vld_nxt  = 1'b0;
      last_nxt = 1'b0;
    end
  end

  // Control and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      frame_id_q    <= '0;
      frame_index_q <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      frame_id_q    <= frame_id_d;
      frame_index_q <= frame_index_d;
    end
  end

  // ---- stage p0: registered ROM slice with tags, offered downstream ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0  <= '0;
      class_p0 <= '0;
      frame_p0 <= '0;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      data_p0  <= data_nxt;
      class_p0 <= class_nxt;
      frame_p0 <= frame_nxt;
      vld_p0   <= vld_nxt;
      last_p0  <= last_nxt;
    end
  end

  assign frame_id_o    = frame_id_q;
  assign frame_index_o = frame_index_q;
  assign out_data_o    = data_p0;
  assign out_class_o   = class_p0;
  assign out_frame_o   = frame_p0;
  assign out_valid_o   = vld_p0;
  assign out_last_o    = last_p0;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == FIN);

endmodule

// File: tb/tb_class_hvec_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for class_hvec_scan_ctrl. It models the ROM as a hash of the
// address. The expected beat list is built from the mask alone: classes in
// ascending order, all frames of each class, and last on the top frame of the
// top class. Accepted beats are compared in order against that list.
// -----------------------------------------------------------------------------
module tb_class_hvec_scan_ctrl;

  localparam int W  = 64;
  localparam int NC = 8;
  localparam int NF = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          abort_i;
  logic [NC-1:0] class_mask_i;
  logic [2:0]    frame_id_o;
  logic [1:0]    frame_index_o;
  logic [W-1:0]  class_vec_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  out_data_o;
  logic [2:0]    out_class_o;
  logic [1:0]    out_frame_o;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] c;
    logic [1:0] f;
    logic       last;
  } beat_t;

  beat_t expq[$];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rom_f(input logic [2:0] c, input logic [1:0] f);
    logic [W-1:0] k;
    k = 64'({c, f}) + 64'd1;
    return (k * 64'h9E3779B97F4A7C15) ^ {c, f, 59'h0};
  endfunction

  assign class_vec_i = rom_f(frame_id_o, frame_index_o);

  class_hvec_scan_ctrl #(
    .DI_PARALLEL_W_BITS(W),
    .N_CLASSES(NC),
    .N_FRAMES(NF),
    .CLASS_W(3),
    .FRAME_W(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .class_mask_i (class_mask_i),
    .frame_id_o   (frame_id_o),
    .frame_index_o(frame_index_o),
    .class_vec_i  (class_vec_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_class_o  (out_class_o),
    .out_frame_o  (out_frame_o),
    .out_last_o   (out_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [NC-1:0] m);
    int    top;
    beat_t b;
    top = -1;
    expq.delete();
    for (int c = 0; c < NC; c++) if (m[c]) top = c;
    for (int c = 0; c < NC; c++) begin
      if (m[c]) begin
        for (int f = 0; f < NF; f++) begin
          b.c    = 3'(c);
          b.f    = 2'(f);
          b.last = (c == top) && (f == NF - 1);
          expq.push_back(b);
        end
      end
    end
  endtask

  task automatic do_start(input logic [NC-1:0] m);
    class_mask_i = m;
    start_i      = 1'b1;
    @(posedge clk); #1;
    start_i      = 1'b0;
    class_mask_i = NC'($urandom);   // a mid-scan mask change must be ignored
  endtask

  // Runs one scan. Cycle 0 is the cycle right after the edge that accepted the start.
  task automatic run_scan(input logic [NC-1:0] m, input int rdy_pct, input int abort_beat,
                          input int start_mid, input string tag);
    int           cyc, acc, n_exp, first_acc, last_acc, done_cnt, done_cyc, busy_cnt;
    logic         stalled, finished, aborted;
    logic [W-1:0] pd;
    logic [2:0]   pc;
    logic [1:0]   pf;
    logic         pl;
    beat_t        b;

    build_exp(m);
    n_exp = expq.size();
    cyc = 0; acc = 0; first_acc = -1; last_acc = -1;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    stalled = 1'b0; finished = 1'b0; aborted = 1'b0;
    pd = '0; pc = '0; pf = '0; pl = 1'b0;

    do_start(m);
    while (!finished && cyc < 600) begin
      out_ready_i = ($urandom_range(99) < rdy_pct);
      start_i     = (cyc == start_mid);
      if (start_i) class_mask_i = 8'h01;

      if (stalled) begin
        check({tag, "_stall_valid"}, 64'(out_valid_o), 64'd1);
        check({tag, "_stall_data"},  out_data_o, pd);
        check({tag, "_stall_tags"},  64'({out_class_o, out_frame_o, out_last_o}), 64'({pc, pf, pl}));
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end

      if (abort_beat >= 0 && acc == abort_beat && out_valid_o) begin
        out_ready_i = 1'b0;
        abort_i     = 1'b1;
        start_i     = 1'b1;   // abort must win over a coincident start
        @(posedge clk); #1;
        abort_i = 1'b0;
        start_i = 1'b0;
        check({tag, "_abort_valid"}, 64'(out_valid_o), 64'd0);
        check({tag, "_abort_last"},  64'(out_last_o),  64'd0);
        check({tag, "_abort_busy"},  64'(busy_o),      64'd0);
        check({tag, "_abort_done"},  64'(done_o),      64'd0);
        @(posedge clk); #1;
        check({tag, "_abort_done2"}, 64'(done_o),      64'd0);
        check({tag, "_abort_busy2"}, 64'(busy_o),      64'd0);
        check({tag, "_abort_valid2"}, 64'(out_valid_o), 64'd0);
        aborted  = 1'b1;
        finished = 1'b1;
      end else begin
        if (out_valid_o && out_ready_i) begin
          if (expq.size() == 0) begin
            check({tag, "_extra_beat"}, 64'd1, 64'd0);
          end else begin
            b = expq.pop_front();
            check({tag, "_class"}, 64'(out_class_o), 64'(b.c));
            check({tag, "_frame"}, 64'(out_frame_o), 64'(b.f));
            check({tag, "_last"},  64'(out_last_o),  64'(b.last));
            check({tag, "_data"},  out_data_o,       rom_f(b.c, b.f));
          end
          acc++;
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
        end
        stalled = out_valid_o && !out_ready_i;
        pd = out_data_o; pc = out_class_o; pf = out_frame_o; pl = out_last_o;
        if (done_cnt > 0 && !busy_o) finished = 1'b1;
        if (!finished) begin
          @(posedge clk); #1;
          cyc++;
        end
      end
    end
    start_i     = 1'b0;
    out_ready_i = 1'b0;

    check({tag, "_timeout"}, 64'(finished), 64'd1);
    if (!aborted) begin
      check({tag, "_beats"},     64'(acc),         64'(n_exp));
      check({tag, "_leftover"},  64'(expq.size()), 64'd0);
      check({tag, "_done_cnt"},  64'(done_cnt),    64'd1);
      if (n_exp > 0) begin
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'(last_acc + 1));
        if (rdy_pct >= 100) begin
          check({tag, "_first_lat"}, 64'(first_acc),           64'd1);
          check({tag, "_back2back"}, 64'(last_acc - first_acc), 64'(n_exp - 1));
        end
      end else begin
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'd0);
        check({tag, "_busy_cyc"}, 64'(busy_cnt), 64'd1);
      end
    end
  endtask

  initial begin
    logic [NC-1:0] rm;
    rst_n        = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    out_ready_i  = 1'b0;
    class_mask_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_last",  64'(out_last_o),  64'd0);
    check("rst_busy",  64'(busy_o),      64'd0);
    check("rst_done",  64'(done_o),      64'd0);
    check("rst_data",  out_data_o,       64'd0);
    check("rst_addr",  64'({frame_id_o, frame_index_o, out_class_o, out_frame_o}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_scan(8'hFF,       100, -1, -1, "full");
    run_scan(8'b10100100, 100, -1, -1, "sparse");
    run_scan(8'h00,       100, -1, -1, "zero");
    run_scan(8'hFF,        50, -1, -1, "stall");
    run_scan(8'hFF,        60, 10, -1, "abort");
    run_scan(8'hFF,       100, -1, -1, "after_abort");
    run_scan(8'hFF,       100, -1,  5, "start_mid");

    // Reset asserted mid-scan, away from the clock edge.
    out_ready_i = 1'b1;
    do_start(8'hFF);
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("pre_rst_valid", 64'(out_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_last",  64'(out_last_o),  64'd0);
    check("arst_busy",  64'(busy_o),      64'd0);
    check("arst_done",  64'(done_o),      64'd0);
    check("arst_data",  out_data_o,       64'd0);
    check("arst_addr",  64'({frame_id_o, frame_index_o, out_class_o, out_frame_o}), 64'd0);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_valid", 64'(out_valid_o), 64'd0);
      check("post_rst_busy",  64'(busy_o),      64'd0);
    end
    out_ready_i = 1'b0;

    for (int i = 0; i < 4; i++) begin
      rm = NC'($urandom);
      run_scan(rm, $urandom_range(100, 30), -1, -1, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
